// File: rtl/ethernet_frame_pkg.sv
// Frame layout constants, FSM state and request capture type for the session-registration responder.
// Shared by axis_session_reg_responder and crc32_d8.
package ethernet_frame_pkg;

    // Byte offsets into the 112-byte registration frame.
    localparam logic [6:0] OFF_SWHWM_SRC_MAC = 7'd6;
    localparam logic [6:0] OFF_MSG_TYPE      = 7'd14;
    localparam logic [6:0] OFF_REQ_ID        = 7'd16;
    localparam logic [6:0] OFF_SESS_ID       = 7'd20;
    localparam logic [6:0] OFF_EXCH          = 7'd21;
    localparam logic [6:0] OFF_ETH           = 7'd22;
    localparam logic [6:0] OFF_FCS           = 7'd108;
    localparam logic [6:0] OFF_LAST          = 7'd111;

    localparam logic [4:0] ACCEPT_MSG_BYTES  = 5'd20;
    localparam logic [4:0] REJECT_MSG_BYTES  = 5'd21;

    localparam logic [7:0] REJECT_SESS_ID_RANGE = 8'h01;

    typedef enum logic [1:0] {
        ST_RX      = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_TX_RESP = 2'd2
    } sess_state_e;

    typedef struct packed {
        logic [47:0] src_mac;
        logic [15:0] msg_type;
        logic [31:0] req_id;
        logic [7:0]  sess_id;
        logic [7:0]  exch;
    } sess_req_t;

    // One byte of reflected CRC-32 (poly 0x04C11DB7, bit-reversed form 0xEDB88320).
    function automatic logic [31:0] crc32_byte_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-serial CRC-32 accumulator; crc holds the running (un-inverted) register.
// Used only when SESSION_REG_FCS_CHECK_EN is defined.
module crc32_d8
    import ethernet_frame_pkg::*;
(
    input  logic        gclk,
    input  logic        grst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            crc <= 32'hFFFF_FFFF;
        else if (clr)
            crc <= 32'hFFFF_FFFF;
        else if (en)
            crc <= crc32_byte_step(crc, data);
    end

endmodule

// File: rtl/axis_session_reg_responder.sv
// Consumes 112-byte session-registration frames and emits accept/reject responses plus a session-table write.
// Optional FCS check over the embedded Ethernet region: define SESSION_REG_FCS_CHECK_EN.
module axis_session_reg_responder
    import ethernet_frame_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC         = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE         = 16'h88B5,
    parameter logic [15:0] MSG_TYPE_SESS_REG = 16'h0001,
    parameter logic [15:0] MSG_TYPE_ACCEPT   = 16'h0002,
    parameter logic [15:0] MSG_TYPE_REJECT   = 16'h0003,
    parameter int          MAX_SESSION_ID    = 63
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        sess_wr_valid,
    output logic [5:0]  sess_wr_id,
    output logic [7:0]  sess_wr_exch,
    output logic [31:0] sess_wr_req_id,
    output logic [15:0] stat_accept_cnt,
    output logic [15:0] stat_reject_cnt,
    output logic [15:0] stat_drop_cnt
);

    sess_state_e state;
    sess_req_t   req;
    logic [6:0]  byte_cnt;
    logic [4:0]  tx_idx;
    logic        is_reject;

    logic        s_hs, m_hs, rx_hs;
    logic        fcs_ok, sess_in_range;
    logic [4:0]  tx_last_idx, tx_sel, tx_rev;
    logic [167:0] resp_hdr;
    logic [7:0]  tx_byte;

    assign s_hs  = s_axis_tvalid & s_axis_tready;
    assign m_hs  = m_axis_tvalid & m_axis_tready;
    assign rx_hs = s_hs && (state == ST_RX);

    assign sess_in_range = 32'(req.sess_id) <= 32'(MAX_SESSION_ID);

`ifdef SESSION_REG_FCS_CHECK_EN
    logic [31:0] crc_state;
    logic [23:0] fcs_lo;

    crc32_d8 u_crc (
        .gclk   (aclk),
        .grst_n (aresetn),
        .clr    (rx_hs && byte_cnt == 7'd0),
        .en     (rx_hs && byte_cnt >= OFF_ETH && byte_cnt < OFF_FCS),
        .data   (s_axis_tdata),
        .crc    (crc_state)
    );

    // FCS arrives LSB first; the last byte is still on the bus in the evaluation cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            fcs_lo <= '0;
        else if (rx_hs && byte_cnt >= OFF_FCS)
            fcs_lo <= {s_axis_tdata, fcs_lo[23:8]};
    end

    assign fcs_ok = (~crc_state) == {s_axis_tdata, fcs_lo};
`else
    assign fcs_ok = 1'b1;
`endif

    // Response is a fixed 21-byte image; accepts simply stop one byte early.
    assign resp_hdr    = {req.src_mac, LOCAL_MAC, ETHERTYPE,
                          is_reject ? MSG_TYPE_REJECT : MSG_TYPE_ACCEPT,
                          req.req_id, REJECT_SESS_ID_RANGE};
    assign tx_last_idx = is_reject ? REJECT_MSG_BYTES - 5'd1 : ACCEPT_MSG_BYTES - 5'd1;
    assign tx_sel      = (state == ST_TX_RESP && tx_idx != tx_last_idx) ? tx_idx + 5'd1 : 5'd0;
    assign tx_rev      = (REJECT_MSG_BYTES - 5'd1) - tx_sel;
    assign tx_byte     = resp_hdr[{tx_rev, 3'b000} +: 8];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= ST_RX;
            req             <= '0;
            byte_cnt        <= '0;
            tx_idx          <= '0;
            is_reject       <= 1'b0;
            s_axis_tready   <= 1'b0;
            m_axis_tdata    <= '0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            sess_wr_valid   <= 1'b0;
            sess_wr_id      <= '0;
            sess_wr_exch    <= '0;
            sess_wr_req_id  <= '0;
            stat_accept_cnt <= '0;
            stat_reject_cnt <= '0;
            stat_drop_cnt   <= '0;
        end else begin
            sess_wr_valid <= 1'b0;
            case (state)
                ST_RX: begin
                    s_axis_tready <= 1'b1;
                    if (s_hs) begin
                        byte_cnt <= byte_cnt + 7'd1;
                        if (byte_cnt >= OFF_SWHWM_SRC_MAC && byte_cnt < OFF_SWHWM_SRC_MAC + 7'd6)
                            req.src_mac <= {req.src_mac[39:0], s_axis_tdata};
                        if (byte_cnt == OFF_MSG_TYPE || byte_cnt == OFF_MSG_TYPE + 7'd1)
                            req.msg_type <= {req.msg_type[7:0], s_axis_tdata};
                        if (byte_cnt >= OFF_REQ_ID && byte_cnt < OFF_SESS_ID)
                            req.req_id <= {req.req_id[23:0], s_axis_tdata};
                        if (byte_cnt == OFF_SESS_ID)
                            req.sess_id <= s_axis_tdata;
                        if (byte_cnt == OFF_EXCH)
                            req.exch <= s_axis_tdata;

                        if (s_axis_tlast) begin
                            byte_cnt <= '0;
                            if (byte_cnt != OFF_LAST || req.msg_type != MSG_TYPE_SESS_REG || !fcs_ok) begin
                                stat_drop_cnt <= stat_drop_cnt + 16'd1;
                            end else begin
                                state         <= ST_TX_RESP;
                                s_axis_tready <= 1'b0;
                                m_axis_tvalid <= 1'b1;
                                m_axis_tdata  <= tx_byte;
                                m_axis_tlast  <= 1'b0;
                                tx_idx        <= '0;
                                is_reject     <= !sess_in_range;
                                if (sess_in_range) begin
                                    sess_wr_valid   <= 1'b1;
                                    sess_wr_id      <= req.sess_id[5:0];
                                    sess_wr_exch    <= req.exch;
                                    sess_wr_req_id  <= req.req_id;
                                    stat_accept_cnt <= stat_accept_cnt + 16'd1;
                                end else begin
                                    stat_reject_cnt <= stat_reject_cnt + 16'd1;
                                end
                            end
                        end else if (byte_cnt == OFF_LAST) begin
                            state    <= ST_DRAIN;
                            byte_cnt <= '0;
                        end
                    end
                end

                ST_DRAIN: begin
                    s_axis_tready <= 1'b1;
                    if (s_hs && s_axis_tlast) begin
                        stat_drop_cnt <= stat_drop_cnt + 16'd1;
                        state         <= ST_RX;
                    end
                end

                ST_TX_RESP: begin
                    s_axis_tready <= 1'b0;
                    if (m_hs) begin
                        if (tx_idx == tx_last_idx) begin
                            state         <= ST_RX;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            s_axis_tready <= 1'b1;
                        end else begin
                            tx_idx       <= tx_idx + 5'd1;
                            m_axis_tdata <= tx_byte;
                            m_axis_tlast <= (tx_idx + 5'd1 == tx_last_idx);
                        end
                    end
                end

                default: state <= ST_RX;
            endcase
        end
    end

endmodule
